sprite_mem_writer: RTL and testbench

Loads a sprite into the memories a sprite renderer later reads: a 12-bit colour palette and a WIDTH*HEIGHT array of 8-bit palette indices. It consumes a byte stream, for example from a UART receiver, using a valid/ready handshake. It drives the write ports (we/addr/data) of the palette and image RAMs. It sits between the host-link byte receiver and the dual-port sprite RAMs, so sprites can be replaced at runtime instead of being fixed by .mem init files.

---
 rtl/sprite_mem_writer.sv | 97 +++++++++
 tb/tb_sprite_mem_writer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_mem_writer.sv
// sprite_mem_writer: valid/ready byte-stream loader that drives palette (12-bit) and image (8-bit index) RAM write ports, with busy/done/error status
module sprite_mem_writer #(
  parameter int WIDTH = 100,
  parameter int HEIGHT = 100,
  parameter int PALETTE_DEPTH = 100
) (
  input  logic                               pixel_clk_in,
  input  logic                               rst_in,
  input  logic                               start_in,
  input  logic [7:0]                         data_in,
  input  logic                               valid_in,
  output logic                               ready_out,
  output logic                               palette_we_out,
  output logic [7:0]                         palette_addr_out,
  output logic [11:0]                        palette_data_out,
  output logic                               image_we_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]    image_addr_out,
  output logic [7:0]                         image_data_out,
  output logic                               busy_out,
  output logic                               done_out,
  output logic                               error_out
);
  localparam int AW = $clog2(WIDTH*HEIGHT);
  localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
  localparam logic [7:0] PMAX = 8'(PALETTE_DEPTH - 1);
  localparam logic [8:0] PDEP = 9'(PALETTE_DEPTH);
  typedef enum logic [2:0] {IDLE, PAL_HI, PAL_LO, IMAGE, DONE} state_t;
  state_t state;
  logic [7:0] pal_cnt;
  logic [3:0] nib;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] addr;
  assign ready_out = state inside {PAL_HI, PAL_LO, IMAGE};
  assign busy_out = state != IDLE;
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      pal_cnt <= '0;
      nib <= '0;
      x <= '0;
      y <= '0;
      addr <= '0;
      palette_we_out <= 1'b0;
      palette_addr_out <= '0;
      palette_data_out <= '0;
      image_we_out <= 1'b0;
      image_addr_out <= '0;
      image_data_out <= '0;
      done_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      palette_we_out <= 1'b0;
      image_we_out <= 1'b0;
      done_out <= 1'b0;
      case (state)
        IDLE: if (start_in) begin
          state <= PAL_HI;
          error_out <= 1'b0;
          pal_cnt <= '0;
          x <= '0;
          y <= '0;
          addr <= '0;
        end
        PAL_HI: if (valid_in) begin
          nib <= data_in[3:0];
          state <= PAL_LO;
        end
        PAL_LO: if (valid_in) begin
          palette_we_out <= 1'b1;
          palette_addr_out <= pal_cnt;
          palette_data_out <= {nib, data_in};
          pal_cnt <= pal_cnt + 8'd1;
          state <= pal_cnt == PMAX ? IMAGE : PAL_HI;
        end
        IMAGE: if (valid_in) begin
          image_we_out <= 1'b1;
          image_addr_out <= addr;
          image_data_out <= data_in;
          addr <= addr + AW'(1);
          x <= x == XMAX ? '0 : x + XW'(1);
          if (x == XMAX) y <= y + YW'(1);
          if ({1'b0, data_in} >= PDEP) error_out <= 1'b1;
          if (x == XMAX && y == YMAX) begin
            state <= DONE;
            done_out <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_mem_writer.sv
// tb_sprite_mem_writer: table-driven and randomized-stall checks of sprite_mem_writer against a byte-transaction reference model
module tb_sprite_mem_writer;
  localparam int W = 4, H = 3, PD = 4, NB = 2*PD + W*H;
  logic clk = 0, rst = 1, start = 0, valid = 0;
  logic [7:0] din = 0;
  logic ready, pwe, iwe, busy, done, err;
  logic [7:0] paddr, idata;
  logic [11:0] pdata;
  logic [3:0] iaddr;
  int checks = 0, errors = 0;
  int pcnt = 0, icnt = 0, dcnt = 0;
  int n = 0;
  logic loading = 0, pp = 0, pi = 0, pdn = 0, merr = 0;
  logic [7:0] hi = 0, ppa = 0, pid = 0;
  logic [11:0] ppd = 0;
  logic [3:0] pia = 0;
  typedef struct {
    int stall;
    logic [7:0] hi, lo;
    int bad_pos;
    logic [7:0] bad_val;
    bit mid_start, rnd, exp_err;
  } vec_t;
  vec_t vt[6];
  always #5 clk = ~clk;
  sprite_mem_writer #(.WIDTH(W), .HEIGHT(H), .PALETTE_DEPTH(PD)) dut (
    .pixel_clk_in(clk), .rst_in(rst), .start_in(start), .data_in(din), .valid_in(valid),
    .ready_out(ready), .palette_we_out(pwe), .palette_addr_out(paddr), .palette_data_out(pdata),
    .image_we_out(iwe), .image_addr_out(iaddr), .image_data_out(idata),
    .busy_out(busy), .done_out(done), .error_out(err)
  );
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task monitor();
    logic wd;
    forever begin
      @(negedge clk);
      chk("ready", int'(ready), int'(loading));
      chk("busy", int'(busy), int'(loading || pdn));
      chk("pal_we", int'(pwe), int'(pp));
      if (pp) begin
        chk("pal_addr", int'(paddr), int'(ppa));
        chk("pal_data", int'(pdata), int'(ppd));
      end
      chk("img_we", int'(iwe), int'(pi));
      if (pi) begin
        chk("img_addr", int'(iaddr), int'(pia));
        chk("img_data", int'(idata), int'(pid));
      end
      chk("done", int'(done), int'(pdn));
      chk("error", int'(err), int'(merr));
      pcnt += int'(pwe);
      icnt += int'(iwe);
      dcnt += int'(done);
      wd = pdn;
      pp = 0;
      pi = 0;
      pdn = 0;
      if (rst) begin
        loading = 0;
        merr = 0;
        n = 0;
      end else if (!loading && !wd && start) begin
        loading = 1;
        merr = 0;
        n = 0;
      end else if (loading && valid) begin
        if (n < 2*PD) begin
          if (n % 2 == 0) hi = din;
          else begin
            pp = 1;
            ppa = 8'(n/2);
            ppd = {hi[3:0], din};
          end
        end else begin
          pi = 1;
          pia = 4'(n - 2*PD);
          pid = din;
          if (din >= 8'(PD)) merr = 1;
          if (n == NB - 1) begin
            pdn = 1;
            loading = 0;
          end
        end
        n++;
      end
    end
  endtask
  task automatic send(input logic [7:0] b, input int stall, inout int edges);
    logic a;
    while ($urandom_range(99) < stall) begin
      valid = 0;
      din = 8'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    valid = 1;
    din = b;
    for (int g = 0; ; g++) begin
      a = ready;
      @(posedge clk); #1;
      edges++;
      if (a) break;
      if (g > 20) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: byte %0h not accepted within 20 cycles", b);
        break;
      end
    end
    valid = 0;
  endtask
  task automatic run_load(input vec_t v);
    int p0, i0, d0, edges;
    logic [7:0] b;
    p0 = pcnt;
    i0 = icnt;
    d0 = dcnt;
    edges = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < PD; i++) begin
      send(v.hi, v.stall, edges);
      send(v.lo, v.stall, edges);
    end
    for (int k = 0; k < W*H; k++) begin
      if (v.mid_start && k == 6) begin
        start = 1;
        @(posedge clk); #1;
        start = 0;
      end
      b = v.rnd ? 8'($urandom_range(PD - 1)) : 8'(k % 4);
      if (k == v.bad_pos) b = v.bad_val;
      send(b, v.stall, edges);
    end
    chk("done_with_last", int'(done && iwe && iaddr == 4'(W*H - 1)), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("pal_writes", pcnt - p0, PD);
    chk("img_writes", icnt - i0, W*H);
    chk("done_pulses", dcnt - d0, 1);
    chk("error_after", int'(err), int'(v.exp_err));
    chk("busy_after", int'(busy), 0);
    if (v.stall == 0) chk("no_bubbles", edges, NB);
  endtask
  initial begin
    int e, d0;
    vt[0] = '{0,  8'h0F, 8'hA5, -1, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[1] = '{40, 8'h0F, 8'hA5, -1, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[2] = '{0,  8'h0F, 8'hA5, 3,  8'h07, 1'b0, 1'b0, 1'b1};
    vt[3] = '{30, 8'h3C, 8'h5A, -1, 8'h00, 1'b1, 1'b1, 1'b0};
    vt[4] = '{60, 8'hF2, 8'h00, 11, 8'hFF, 1'b0, 1'b1, 1'b1};
    vt[5] = '{0,  8'h81, 8'h7E, 0,  8'h04, 1'b1, 1'b0, 1'b1};
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_ready", int'(ready), 0);
    chk("rst_outputs", int'({pwe, paddr, pdata, iwe, iaddr, idata, busy, done, err}), 0);
    for (int i = 0; i < 5; i++) begin
      valid = 1;
      din = 8'($urandom);
      @(posedge clk); #1;
      chk("idle_ready", int'(ready), 0);
      chk("idle_strobes", int'({pwe, iwe, busy, done}), 0);
    end
    valid = 0;
    foreach (vt[i]) run_load(vt[i]);
    e = 0;
    d0 = dcnt;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 2*PD; i++) send(8'h12, 0, e);
    for (int k = 0; k < 6; k++) send(8'(k), 0, e);
    chk("mid_addr5_we", int'(iwe), 1);
    chk("mid_addr5", int'(iaddr), 5);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mid_rst_outputs", int'({pwe, paddr, pdata, iwe, iaddr, idata, busy, done, err, ready}), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_done", dcnt - d0, 0);
    run_load(vt[1]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
